// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle RV64M multiply/divide unit: op and state encodings,
// iteration counts, and the latched request record.
package muldiv_pkg;

  localparam int MD_XLEN    = 64;
  localparam int MD_TAG_W   = 5;
  localparam int XLEN_ITERS = 64;
  localparam int W_ITERS    = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } muldiv_state_e;

  typedef struct packed {
    muldiv_op_e            funct3;
    logic                  width_32;
    logic [MD_XLEN-1:0]    a;
    logic [MD_XLEN-1:0]    b;
    logic [MD_TAG_W-1:0]   tag;
  } muldiv_req_t;

  function automatic logic [MD_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MD_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle datapath: right-shifting shift-add multiply or restoring divide on a
// shared 2*XLEN+1 register. Result is ready the cycle after the last step; no backpressure.
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_init,
  input  logic [XLEN-1:0]   i_addend,
  output logic [2*XLEN-1:0] o_acc
);

  // Multiply: {carry+high, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*XLEN:0] r_acc;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shl;
  logic [XLEN+1:0] w_diff;
  logic [2*XLEN:0] w_mul_nxt;
  logic [2*XLEN:0] w_div_nxt;

  always_comb begin
    w_sum     = r_acc[2*XLEN:XLEN] + {1'b0, i_addend};
    w_mul_nxt = {1'b0, (r_acc[0] ? w_sum : r_acc[2*XLEN:XLEN]), r_acc[XLEN-1:1]};
    w_shl     = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_diff    = {1'b0, w_shl} - {2'b00, i_addend};
    // Borrow out means the trial subtraction failed: keep the shifted remainder.
    w_div_nxt = {(w_diff[XLEN+1] ? w_shl : w_diff[XLEN:0]), r_acc[XLEN-2:0], ~w_diff[XLEN+1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= {{(XLEN+1){1'b0}}, i_init};
    end else if (i_step) begin
      r_acc <= i_is_div ? w_div_nxt : w_mul_nxt;
    end
  end

  assign o_acc = r_acc[2*XLEN-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// RV64M multi-cycle mul/div: result valid K+3 cycles after accept (2 for div-by-zero/overflow).
// Accepts only in IDLE; result held in DONE until out_ready, flush aborts to IDLE.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_width_32,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN_ITERS);

  muldiv_state_e    r_state;
  muldiv_req_t      r_req;
  muldiv_op_e       r_op;
  logic             r_is_div, r_is_w, r_is_rem, r_neg;
  logic [CNT_W-1:0] r_cnt, r_last;
  logic [XLEN-1:0]  r_addend;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  muldiv_op_e        w_op;
  logic              w_is_div, w_is_w, w_sgn_div, w_sgn_a, w_sgn_b;
  logic              w_neg_a, w_neg_b, w_div0, w_ovf;
  logic [XLEN-1:0]   w_ext_a, w_ext_b, w_mag_a, w_mag_b, w_init, w_fast_val, w_fast;
  logic [2*XLEN-1:0] w_acc, w_prod;
  logic [XLEN-1:0]   w_dv, w_dv_s, w_raw, w_fix;

  // PREP: operand conditioning from the latched request.
  always_comb begin
    w_op      = r_req.funct3;
    w_is_div  = w_op[2];
    w_is_w    = r_req.width_32 && (w_op == OP_MUL || w_is_div);
    w_sgn_div = w_is_div && !w_op[0];
    w_sgn_a   = w_sgn_div || w_op == OP_MULH || w_op == OP_MULHSU;
    w_sgn_b   = w_sgn_div || w_op == OP_MULH;
    w_ext_a   = !w_is_w ? r_req.a : (w_sgn_div ? sext32(r_req.a[31:0]) : {32'b0, r_req.a[31:0]});
    w_ext_b   = !w_is_w ? r_req.b : (w_sgn_div ? sext32(r_req.b[31:0]) : {32'b0, r_req.b[31:0]});
    w_neg_a   = w_sgn_a && w_ext_a[XLEN-1];
    w_neg_b   = w_sgn_b && w_ext_b[XLEN-1];
    w_mag_a   = w_neg_a ? -w_ext_a : w_ext_a;
    w_mag_b   = w_neg_b ? -w_ext_b : w_ext_b;
    w_div0    = w_is_div && (w_ext_b == '0);
    w_ovf     = w_sgn_div && (&w_ext_b) &&
                (w_ext_a == (w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    w_fast_val = w_div0 ? (w_op[1] ? w_ext_a : '1) : (w_op[1] ? '0 : w_ext_a);
    w_fast     = w_is_w ? sext32(w_fast_val[31:0]) : w_fast_val;
    // W-form dividends sit in the top half so 32 steps consume exactly their bits.
    w_init     = w_is_div ? (w_is_w ? {w_mag_a[31:0], 32'b0} : w_mag_a) : w_mag_b;
  end

  // FIX: sign correction and result select from the iterated register.
  always_comb begin
    w_prod = r_neg ? -w_acc : w_acc;
    w_dv   = r_is_rem ? w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
    w_dv_s = r_neg ? -w_dv : w_dv;
    if (r_is_div)           w_raw = w_dv_s;
    else if (r_op != OP_MUL) w_raw = w_prod[2*XLEN-1:XLEN];
    else if (r_is_w)        w_raw = {32'b0, w_acc[63:32]};
    else                    w_raw = w_acc[XLEN-1:0];
    w_fix = r_is_w ? sext32(w_raw[31:0]) : w_raw;
  end

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (r_state == S_PREP),
    .i_step   (r_state == S_CALC),
    .i_is_div (r_is_div),
    .i_init   (w_init),
    .i_addend (r_addend),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_op         <= OP_MUL;
      r_is_div     <= 1'b0;
      r_is_w       <= 1'b0;
      r_is_rem     <= 1'b0;
      r_neg        <= 1'b0;
      r_cnt        <= '0;
      r_last       <= '0;
      r_addend     <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_req   <= '{funct3: muldiv_op_e'(in_funct3), width_32: in_width_32,
                       a: in_a, b: in_b, tag: in_tag};
          r_state <= S_PREP;
        end
        S_PREP: begin
          r_op     <= w_op;
          r_is_div <= w_is_div;
          r_is_w   <= w_is_w;
          r_is_rem <= w_op[1];
          r_neg    <= (w_is_div && w_op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
          r_addend <= w_is_div ? w_mag_b : w_mag_a;
          r_last   <= w_is_w ? CNT_W'(W_ITERS - 1) : CNT_W'(XLEN_ITERS - 1);
          r_cnt    <= '0;
          if (w_div0 || w_ovf) begin
            r_out_result <= w_fast;
            r_out_tag    <= r_req.tag;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == r_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_out_result <= w_fix;
          r_out_tag    <= r_req.tag;
          r_out_valid  <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_width_32;
  logic        out_valid, out_ready, busy;
  logic [2:0]  in_funct3;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_width_32(in_width_32), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic eff_w(input logic [2:0] f, input logic w);
    return w && (f == 3'b000 || f[2]);
  endfunction

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic signed [127:0] pa, pb, p;
    logic signed [63:0] sa, sb;
    logic [63:0] r;
    a32 = a[31:0]; b32 = b[31:0];
    sa = a; sb = b;
    if (eff_w(f, w)) begin
      case (f)
        3'b000: r32 = a32 * b32;
        3'b100: r32 = (b32 == 0) ? 32'hFFFF_FFFF :
                      (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? a32 :
                      32'($signed(a32) / $signed(b32));
        3'b101: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
        3'b110: r32 = (b32 == 0) ? a32 :
                      (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? 32'h0 :
                      32'($signed(a32) % $signed(b32));
        default: r32 = (b32 == 0) ? a32 : a32 % b32;
      endcase
      return sx(r32);
    end
    case (f)
      3'b000: r = a * b;
      3'b001: begin pa = $signed(a); pb = $signed(b); p = pa * pb; r = p[127:64]; end
      3'b010: begin pa = $signed(a); pb = {64'b0, b}; p = pa * pb; r = p[127:64]; end
      3'b011: begin pa = {64'b0, a}; pb = {64'b0, b}; p = pa * pb; r = p[127:64]; end
      3'b100: r = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && &b) ? a : 64'(sa / sb);
      3'b101: r = (b == 0) ? '1 : a / b;
      3'b110: r = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && &b) ? 64'h0 : 64'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    logic ew, zero, ovf;
    ew = eff_w(f, w);
    if (f[2]) begin
      zero = ew ? (b[31:0] == 0) : (b == 0);
      ovf  = !f[0] && (ew ? (a[31:0] == 32'h8000_0000 && &b[31:0])
                          : (a == 64'h8000_0000_0000_0000 && &b));
      if (zero || ovf) return 2;
    end
    return ew ? 35 : 67;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%h expected=0x%h", name, obs, exp);
    end
  endtask

  // Drive one request; returns at #1 after the accepting edge.
  task automatic start_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f; in_width_32 = w; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the accepting edge (inclusive) to first out_valid.
  task automatic wait_result(output logic [63:0] res, output logic [4:0] rtag, output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result; rtag = out_tag;
  endtask

  task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       output logic [63:0] res, output logic [4:0] rtag, output int lat);
    start_op(f, w, a, b, tag);
    wait_result(res, rtag, lat);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic directed(input string name, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
    logic [63:0] res; logic [4:0] rt; int lat; logic [4:0] tg;
    tg = 5'($urandom);
    do_op(f, w, a, b, tg, res, rt, lat);
    check({name, "_res"}, res, exp);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_tag"}, 64'(rt), 64'(tg));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b, res, sm, hold_res;
    logic [2:0]  f;
    logic        w, seen;
    logic [4:0]  tg, rt, hold_tag;
    int          lat;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_funct3 = '0; in_width_32 = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    directed("div_m20_3",   3'b100, 0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 67);
    directed("rem_m20_3",   3'b110, 0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 67);
    directed("divu_by0",    3'b101, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    directed("remu_by0",    3'b111, 0, 64'h1234, 64'd0, 64'h1234, 2);
    directed("div_ovf",     3'b100, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2);
    directed("rem_ovf",     3'b110, 0, 64'h8000_0000_0000_0000, '1, 64'h0, 2);
    directed("mulhu_max",   3'b011, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67);
    directed("mulh_m1",     3'b001, 0, '1, '1, 64'h0, 67);
    directed("mulhsu_m1_2", 3'b010, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67);
    directed("mulw",        3'b000, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35);
    directed("divw_ovf",    3'b100, 1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2);
    directed("mulh_w_as64", 3'b001, 1, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 67);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom); w = 1'($urandom); tg = 5'($urandom);
      sm = 64'($urandom_range(0, 40)) - 64'd20;
      case ($urandom_range(0, 4))
        0: a = {$urandom, $urandom};
        1: a = sm;
        2: a = 64'h8000_0000_0000_0000;
        3: a = {$urandom, 32'h8000_0000};
        default: a = '1;
      endcase
      case ($urandom_range(0, 4))
        0: b = {$urandom, $urandom};
        1: b = 64'({$urandom} << 32);
        2: b = '1;
        3: b = 64'($urandom_range(0, 40)) - 64'd20;
        default: b = {32'h0, $urandom};
      endcase
      do_op(f, w, a, b, tg, res, rt, lat);
      check($sformatf("rand%0d_f%0d_w%0d_res", i, f, w), res, model(f, w, a, b));
      check($sformatf("rand%0d_lat", i), 64'(lat), 64'(model_lat(f, w, a, b)));
      check($sformatf("rand%0d_tag", i), 64'(rt), 64'(tg));
    end

    // Consumer stall: output held stable while out_ready is low.
    out_ready = 1'b0;
    start_op(3'b100, 0, -64'sd20, 64'd3, 5'd5);
    wait_result(hold_res, hold_tag, lat);
    check("stall_first_res", hold_res, 64'hFFFF_FFFF_FFFF_FFFA);
    check("stall_first_tag", 64'(hold_tag), 64'd5);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_res", out_result, 64'hFFFF_FFFF_FFFF_FFFA);
      check("stall_tag", 64'(out_tag), 64'd5);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    directed("after_stall_remu", 3'b111, 0, 64'd100, 64'd7, 64'd2, 67);

    // Flush at CALC cycle 20 with a competing request that must not be accepted.
    start_op(3'b100, 0, 64'd1000, 64'd7, 5'd9);
    repeat (21) @(posedge clk);
    #1;
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1; in_valid = 1'b1; in_funct3 = 3'b000; in_width_32 = 1'b0;
    in_a = 64'd11; in_b = 64'd13; in_tag = 5'd30;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_out_valid", 64'(seen), 64'd0);
    do_op(3'b000, 0, 64'd3, 64'd5, 5'd17, res, rt, lat);
    check("flush_mul_res", res, 64'd15);
    check("flush_mul_tag", 64'(rt), 64'd17);
    check("flush_mul_lat", 64'(lat), 64'd67);

    // Reset in the middle of CALC.
    start_op(3'b011, 0, '1, '1, 5'd3);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_result", out_result, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    do_op(3'b000, 0, 64'd3, 64'd5, 5'd22, res, rt, lat);
    check("rst_mul_res", res, 64'd15);
    check("rst_mul_tag", 64'(rt), 64'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
